// File: rtl/isp_ctrl_pkg.sv
// Shared constants for the ISP frame-synchronous configuration controller:
// FSM state encoding and config address map.
package isp_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_APPLY   = 2'd2;

  localparam int ADDR_EN     = 0;
  localparam int ADDR_PARAM0 = 1;

endpackage

// File: rtl/isp_timing_mon.sv
// Input video timing monitor: vsync/href edge detect, pixel/line/frame
// counters and per-line / per-frame geometry error flags.
module isp_timing_mon #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        in_href,
  input  logic        in_vsync,
  output logic        vsync_rise,
  output logic [15:0] frame_cnt,
  output logic        line_err,
  output logic        frame_err
);

  logic        r_vsync_d;
  logic        r_href_d;
  logic [15:0] r_pix_cnt;
  logic [15:0] r_line_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_line_err;
  logic        r_frame_err;

  logic w_vsync_rise;
  logic w_href_rise;
  logic w_href_fall;
  logic w_pix_bad;
  logic w_frame_bad;

  assign w_vsync_rise = in_vsync & ~r_vsync_d;
  assign w_href_rise  = in_href & ~r_href_d;
  assign w_href_fall  = ~in_href & r_href_d;
  assign w_pix_bad    = w_href_fall & (r_pix_cnt != 16'(WIDTH));
  // The very first vsync has no preceding frame to judge.
  assign w_frame_bad  = (r_frame_cnt != 16'd0) &
                        ((r_line_cnt != 16'(HEIGHT)) | r_line_err);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d   <= 1'b0;
      r_href_d    <= 1'b0;
      r_pix_cnt   <= 16'd0;
      r_line_cnt  <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_vsync_d <= in_vsync;
      r_href_d  <= in_href;

      if (in_href) begin
        if (r_pix_cnt != 16'hFFFF) r_pix_cnt <= r_pix_cnt + 16'd1;
      end else if (w_href_fall) begin
        r_pix_cnt <= 16'd0;
      end

      // A line starting on the vsync cycle belongs to the new frame.
      if (w_vsync_rise) begin
        r_line_cnt <= w_href_rise ? 16'd1 : 16'd0;
      end else if (w_href_rise && (r_line_cnt != 16'hFFFF)) begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end

      if (w_vsync_rise)   r_line_err <= 1'b0;
      else if (w_pix_bad) r_line_err <= 1'b1;

      if (w_vsync_rise) r_frame_cnt <= r_frame_cnt + 16'd1;

      r_frame_err <= w_vsync_rise & w_frame_bad;
    end
  end

  assign vsync_rise = w_vsync_rise;
  assign frame_cnt  = r_frame_cnt;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/isp_frame_ctrl.sv
// Frame-synchronous ISP stage configuration: shadow registers written by
// software, copied to the active set on commit at the next vsync (or forced).
module isp_frame_ctrl
  import isp_ctrl_pkg::*;
#(
  parameter int                    WIDTH      = 1280,
  parameter int                    HEIGHT     = 960,
  parameter int                    NUM_STAGES = 13,
  parameter int                    NUM_PARAMS = 8,
  parameter int                    DATA_W     = 16,
  parameter int                    ADDR_W     = 4,
  parameter logic [NUM_STAGES-1:0] EN_RST     = '0
) (
  input  logic                         pclk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]            cfg_wdata,
  input  logic                         cfg_commit,
  input  logic                         cfg_force,
  input  logic                         in_href,
  input  logic                         in_vsync,
  output logic [NUM_STAGES-1:0]        stage_en,
  output logic [NUM_PARAMS*DATA_W-1:0] param_q,
  output logic                         commit_pending,
  output logic                         commit_done,
  output logic                         addr_err,
  output logic [15:0]                  frame_cnt,
  output logic                         line_err,
  output logic                         frame_err
);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [NUM_STAGES-1:0] r_shadow_en;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_commit_done;
  logic                  r_addr_err;

  logic w_vsync_rise;
  logic w_accept;
  logic w_apply;
  logic w_addr_bad;

  assign cfg_ready  = (r_state != ST_APPLY);
  assign w_accept   = cfg_valid & cfg_ready;
  assign w_apply    = (r_state == ST_APPLY);
  assign w_addr_bad = (cfg_addr > ADDR_W'(NUM_PARAMS));

  isp_timing_mon #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_timing_mon (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .in_href    (in_href),
    .in_vsync   (in_vsync),
    .vsync_rise (w_vsync_rise),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  // Extra commits while pending or applying simply fold into the current one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_commit) begin
          if (cfg_force || w_vsync_rise) w_state_next = ST_APPLY;
          else                           w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_vsync_rise || (cfg_commit && cfg_force)) w_state_next = ST_APPLY;
      end
      ST_APPLY: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shadow_en   <= '0;
      r_stage_en    <= EN_RST;
      r_commit_done <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_commit_done <= w_apply;
      r_addr_err    <= w_accept & w_addr_bad;
      if (w_accept && (cfg_addr == ADDR_W'(ADDR_EN)))
        r_shadow_en <= cfg_wdata[NUM_STAGES-1:0];
      if (w_apply)
        r_stage_en <= r_shadow_en;
    end
  end

  for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_active;

    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_accept && (cfg_addr == ADDR_W'(gi + ADDR_PARAM0)))
          r_shadow <= cfg_wdata;
        if (w_apply)
          r_active <= r_shadow;
      end
    end

    assign param_q[gi*DATA_W +: DATA_W] = r_active;
  end

  assign stage_en       = r_stage_en;
  assign commit_pending = (r_state == ST_PENDING);
  assign commit_done    = r_commit_done;
  assign addr_err       = r_addr_err;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Self-checking bench for isp_frame_ctrl: commit scoreboard, address-map
// vector table and hand-sequenced frame-boundary / timing-monitor cases.
module tb_isp_frame_ctrl;

  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 4;
  localparam int NUM_STAGES = 13;
  localparam int NUM_PARAMS = 8;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;

  logic                         pclk;
  logic                         rst_n;
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [ADDR_W-1:0]            cfg_addr;
  logic [DATA_W-1:0]            cfg_wdata;
  logic                         cfg_commit;
  logic                         cfg_force;
  logic                         in_href;
  logic                         in_vsync;
  logic [NUM_STAGES-1:0]        stage_en;
  logic [NUM_PARAMS*DATA_W-1:0] param_q;
  logic                         commit_pending;
  logic                         commit_done;
  logic                         addr_err;
  logic [15:0]                  frame_cnt;
  logic                         line_err;
  logic                         frame_err;

  isp_frame_ctrl #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .NUM_STAGES (NUM_STAGES),
    .NUM_PARAMS (NUM_PARAMS),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .EN_RST     ('0)
  ) dut (
    .pclk           (pclk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_commit     (cfg_commit),
    .cfg_force      (cfg_force),
    .in_href        (in_href),
    .in_vsync       (in_vsync),
    .stage_en       (stage_en),
    .param_q        (param_q),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .addr_err       (addr_err),
    .frame_cnt      (frame_cnt),
    .line_err       (line_err),
    .frame_err      (frame_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [NUM_STAGES-1:0]        en;
    logic [NUM_PARAMS*DATA_W-1:0] pq;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  exp_t                  sb_q[$];
  logic [NUM_STAGES-1:0] model_en;
  logic [DATA_W-1:0]     model_p[NUM_PARAMS];
  vec_t                  vecs[6];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_PARAMS*DATA_W-1:0] pack_model();
    logic [NUM_PARAMS*DATA_W-1:0] r;
    for (int i = 0; i < NUM_PARAMS; i++) r[i*DATA_W +: DATA_W] = model_p[i];
    return r;
  endfunction

  task automatic model_reset();
    model_en = '0;
    for (int i = 0; i < NUM_PARAMS; i++) model_p[i] = '0;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (a == 0) model_en = d[NUM_STAGES-1:0];
    else if (int'(a) <= NUM_PARAMS) model_p[int'(a) - 1] = d;
  endtask

  task automatic push_exp();
    exp_t e;
    e.en = model_en;
    e.pq = pack_model();
    sb_q.push_back(e);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_valid = 1'b0;
    model_write(a, d);
    $display("[TB] write addr=%0d data=%0h", a, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic send_line(input int n);
    in_href = 1'b1;
    repeat (n) tick();
    in_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int lines, input int short_line);
    for (int l = 0; l < lines; l++) send_line((l == short_line) ? WIDTH - 1 : WIDTH);
  endtask

  task automatic vsync_pulse(input logic exp_ferr);
    in_vsync = 1'b1;
    tick();
    check("frame_err_pulse", frame_err, exp_ferr);
    in_vsync = 1'b0;
    tick();
    check("frame_err_clear", frame_err, 1'b0);
    $display("[TB] vsync frame_cnt=%0d frame_err_exp=%0b", frame_cnt, exp_ferr);
    repeat (2) tick();
  endtask

  // Scoreboard: every commit_done pulse must match the oldest expected apply.
  always @(negedge pclk) begin
    if (rst_n && commit_done) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: commit_done with no apply expected, stage_en=%0h", stage_en);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (stage_en !== e.en || param_q !== e.pq) begin
          fails++;
          $display("FAIL sb_apply: got en=%0h pq=%0h expected en=%0h pq=%0h",
                   stage_en, param_q, e.en, e.pq);
        end else begin
          $display("[TB] apply en=%0h pq=%0h", stage_en, param_q);
        end
      end
    end
  end

  initial begin
    logic [NUM_PARAMS*DATA_W-1:0] pq;

    vecs[0] = '{addr: 4'd8,  data: 16'h0808, exp_err: 1'b0};
    vecs[1] = '{addr: 4'd9,  data: 16'hDEAD, exp_err: 1'b1};
    vecs[2] = '{addr: 4'd12, data: 16'hBAD0, exp_err: 1'b1};
    vecs[3] = '{addr: 4'd15, data: 16'hFFFF, exp_err: 1'b1};
    vecs[4] = '{addr: 4'd0,  data: 16'h0123, exp_err: 1'b0};
    vecs[5] = '{addr: 4'd1,  data: 16'h00AA, exp_err: 1'b0};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_commit = 1'b0; cfg_force = 1'b0; in_href = 1'b0; in_vsync = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state
    check("rst_stage_en", stage_en, '0);
    check("rst_param_q", param_q, '0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_frame_cnt", frame_cnt, '0);
    check("rst_pending", commit_pending, 1'b0);

    // 2: commit mid-frame waits for vsync; write while pending is included
    do_write(4'd0, 16'h1FFF);
    do_write(4'd1, 16'h0040);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("t2_pending", commit_pending, 1'b1);
    do_write(4'd6, 16'h5555);
    repeat (2) tick();
    check("t2_hold_en", stage_en, '0);
    check("t2_still_pending", commit_pending, 1'b1);
    in_vsync = 1'b1;
    push_exp();
    tick();
    in_vsync = 1'b0;
    check("t2_apply_no_done", commit_done, 1'b0);
    check("t2_apply_old_en", stage_en, '0);
    tick();
    pq = param_q;
    check("t2_done", commit_done, 1'b1);
    check("t2_stage_en", stage_en, 13'h1FFF);
    check("t2_param0", pq[15:0], 16'h0040);
    check("t2_pending_clr", commit_pending, 1'b0);
    tick();
    check("t2_done_pulse", commit_done, 1'b0);

    // 3: forced commit, write stalled during APPLY
    do_write(4'd0, 16'h0005);
    do_write(4'd3, 16'h1234);
    cfg_commit = 1'b1;
    cfg_force  = 1'b1;
    push_exp();
    tick();
    cfg_commit = 1'b0;
    cfg_force  = 1'b0;
    cfg_valid  = 1'b1;
    cfg_addr   = 4'd3;
    cfg_wdata  = 16'hBEEF;
    check("t3_ready_low", cfg_ready, 1'b0);
    check("t3_old_en", stage_en, 13'h1FFF);
    tick();
    check("t3_done", commit_done, 1'b1);
    check("t3_new_en", stage_en, 13'h0005);
    check("t3_ready_back", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    model_write(4'd3, 16'hBEEF);
    $display("[TB] write addr=3 data=beef (stalled one cycle)");

    // 4: write + commit + vsync in one cycle; frame had no lines -> frame_err
    cfg_valid  = 1'b1;
    cfg_addr   = 4'd4;
    cfg_wdata  = 16'h0777;
    cfg_commit = 1'b1;
    in_vsync   = 1'b1;
    model_write(4'd4, 16'h0777);
    push_exp();
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    in_vsync   = 1'b0;
    check("t4_apply_state", cfg_ready, 1'b0);
    check("t4_frame_err", frame_err, 1'b1);
    tick();
    pq = param_q;
    check("t4_done", commit_done, 1'b1);
    check("t4_param3", pq[63:48], 16'h0777);
    check("t4_param2", pq[47:32], 16'hBEEF);
    repeat (2) tick();

    // 5: timing monitor over three frames
    do_reset();
    vsync_pulse(1'b0);
    send_frame(HEIGHT, -1);
    check("t5_f1_line_err", line_err, 1'b0);
    vsync_pulse(1'b0);
    send_frame(HEIGHT - 1, -1);
    vsync_pulse(1'b1);
    send_frame(HEIGHT, 2);
    check("t5_f3_line_err", line_err, 1'b1);
    check("t5_frame_cnt3", frame_cnt, 16'd3);
    vsync_pulse(1'b1);
    check("t5_line_err_clr", line_err, 1'b0);
    check("t5_frame_cnt4", frame_cnt, 16'd4);

    // 6a: address map vectors
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].data);
      check($sformatf("t6_addr_err_%0d", vecs[i].addr), addr_err, vecs[i].exp_err);
    end
    tick();
    check("t6_addr_err_clr", addr_err, 1'b0);
    cfg_commit = 1'b1;
    cfg_force  = 1'b1;
    push_exp();
    tick();
    cfg_commit = 1'b0;
    cfg_force  = 1'b0;
    repeat (2) tick();
    pq = param_q;
    check("t6_param7", pq[127:112], 16'h0808);

    // 6b: reset while pending drops the commit
    do_write(4'd0, 16'h0AAA);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("t6_pending", commit_pending, 1'b1);
    do_reset();
    check("t6_pending_drop", commit_pending, 1'b0);
    vsync_pulse(1'b0);
    repeat (3) tick();
    check("t6_no_apply_en", stage_en, '0);
    check("t6_no_apply_pq", param_q, '0);

    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/isp_frame_ctrl.md
Name: isp_frame_ctrl

Overview:
- Frame-synchronous configuration controller for the ISP raw pipeline (dpc/blc/bnr/dgain… stages).
- Software writes stage enables and stage parameters into shadow registers. A commit request copies them into the active registers only at the next frame boundary (vsync rising edge), so no stage bypass mux switches mid-frame.
- Also monitors input timing: frame counter, plus line and pixel count checks against WIDTH/HEIGHT.

Parameters:
- WIDTH, 1280, expected active pixels per line (href-high cycles)
- HEIGHT, 960, expected lines per frame (href rising edges)
- NUM_STAGES, 13, number of stage enable bits
- NUM_PARAMS, 8, number of parameter registers
- DATA_W, 16, parameter register width
- ADDR_W, 4, config address width
- EN_RST, 0, reset value of stage enables (all stages bypassed)

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  async active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  write accepted when valid&ready
- cfg_addr  in  ADDR_W  0 = enables, 1..NUM_PARAMS = param[addr-1]
- cfg_wdata  in  DATA_W  write data (enables use low NUM_STAGES bits)
- cfg_commit  in  1  single-cycle commit request
- cfg_force  in  1  qualifies cfg_commit: apply without waiting for vsync
- in_href  in  1  pipeline input line valid
- in_vsync  in  1  pipeline input frame sync, active high
- stage_en  out  NUM_STAGES  active stage enables
- param_q  out  NUM_PARAMS*DATA_W  active params, param[i] at bits [i*DATA_W +: DATA_W]
- commit_pending  out  1  commit waiting for boundary
- commit_done  out  1  one-cycle pulse when active regs updated
- addr_err  out  1  one-cycle pulse on accepted write to unmapped address
- frame_cnt  out  16  frames seen, wraps
- line_err  out  1  sticky per frame: some line had pixel count != WIDTH
- frame_err  out  1  one-cycle pulse at frame end if line count != HEIGHT or line_err set

Behaviour:
- Reset (async):
  - stage_en = EN_RST; params, shadows and counters = 0.
  - State IDLE; cfg_ready = 1; all pulses and flags = 0.
  - Any pending commit is dropped.
- vsync_rise = in_vsync & ~vsync_d (vsync_d is registered in_vsync). href_rise and href_fall are formed the same way.
- Writes:
  - A write is accepted in any cycle where cfg_ready = 1.
  - Shadow register updates at the end of the accept cycle.
  - cfg_ready = 0 only in the APPLY state.
  - Address > NUM_PARAMS: write is accepted, discarded, and addr_err pulses the next cycle.
- FSM states: IDLE, PENDING, APPLY.
  - IDLE:
    - cfg_commit & cfg_force -> APPLY.
    - cfg_commit & vsync_rise in the same cycle -> APPLY.
    - cfg_commit alone -> PENDING.
  - PENDING:
    - vsync_rise -> APPLY.
    - cfg_commit & cfg_force -> APPLY.
    - Further cfg_commit is absorbed.
  - APPLY: lasts one cycle; active <= shadow; -> IDLE.
  - cfg_commit while in APPLY is ignored.
- commit_pending = (state == PENDING).
- Latency:
  - vsync_rise in cycle t -> APPLY in t+1 -> new stage_en/param_q and commit_done = 1 in t+2.
  - Force commit in cycle t -> same timing.
- Write and commit in the same cycle: the write lands in shadow first, so it is included in the apply.
- A write made while PENDING is included in the eventual apply.
- Timing monitor:
  - pix_cnt (16 bit, saturating) counts href-high cycles.
  - On href_fall: if pix_cnt != WIDTH, set line_err; then pix_cnt clears.
  - line_cnt (16 bit, saturating) increments on href_rise.
  - On vsync_rise:
    - frame_cnt increments (0xFFFF -> 0).
    - If frame_cnt was nonzero before the increment and (line_cnt != HEIGHT or line_err), frame_err pulses next cycle. The first vsync is not checked.
    - line_cnt and line_err clear.
  - href high on the vsync_rise cycle: that line counts toward the new frame.

Decomposition:
- Package isp_ctrl_pkg: FSM state encoding (IDLE = 0, PENDING = 1, APPLY = 2), address constant ADDR_EN = 0, param base ADDR_PARAM0 = 1.
- Sub-module isp_timing_mon holds the edge detect plus pix/line/frame counters and the error flags. It exports vsync_rise to the FSM.

Test Plan:
1. Reset then read -> stage_en = 0, param_q = 0, cfg_ready = 1, frame_cnt = 0.
2. Write addr0 = 0x1FFF and addr1 = 0x0040, commit at mid-frame -> commit_pending = 1; outputs unchanged until vsync_rise at t; stage_en = 0x1FFF and param[0] = 0x0040 at t+2 with commit_done.
3. Commit with cfg_force, no video -> values applied 2 cycles later; a cfg_valid during the APPLY cycle sees cfg_ready = 0 and completes the cycle after.
4. Write, commit and vsync_rise in the same cycle -> APPLY next cycle, and the new write is present in the output.
5. Frames of 1280x960 then 1280x959, then a line of 1279 -> no error on frame 1; frame_err on frame 2; line_err set and frame_err on frame 3; frame_cnt = 3.
6. Write to addr 12 -> addr_err pulse, no register change. Assert rst_n low while PENDING -> pending dropped, nothing applied after release.
